// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Imported by the arbiter top and its testbench.
package regfile_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_e;

endpackage

// File: rtl/rd_decoder.sv
// Destination-register to one-hot write-enable decoder.
// An enable of 0 yields an all-zero vector.
module rd_decoder #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          en,
    input  logic [ADDR_WIDTH-1:0]         rd,
    output logic [regfile_pkg::NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[rd] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto one register-file write port
// and keeps a pending-write scoreboard filled by decode.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             alu_valid,
    input  logic [ADDR_WIDTH-1:0]            alu_rd,
    input  logic [DATA_WIDTH-1:0]            alu_data,
    output logic                             alu_ready,
    input  logic                             mem_valid,
    input  logic [ADDR_WIDTH-1:0]            mem_rd,
    input  logic [DATA_WIDTH-1:0]            mem_data,
    output logic                             mem_ready,
    input  logic                             issue_valid,
    input  logic [ADDR_WIDTH-1:0]            issue_rd,
    output logic [regfile_pkg::NUM_REGS-1:0] write_enable,
    output logic [DATA_WIDTH-1:0]            write_data,
    output logic [regfile_pkg::NUM_REGS-1:0] busy
);

    import regfile_pkg::*;

    prio_e                 state;
    logic                  fire;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [NUM_REGS-1:0]   clr_mask;
    logic [NUM_REGS-1:0]   set_mask;
    logic [NUM_REGS-1:0]   busy_next;

    // A lone requester always wins; the FSM only breaks ties.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!reset) begin
            alu_ready = alu_valid && (!mem_valid || state == PRIO_ALU);
            mem_ready = mem_valid && (!alu_valid || state == PRIO_MEM);
        end
    end

    assign fire       = alu_ready || mem_ready;
    assign grant_rd   = alu_ready ? alu_rd : mem_rd;
    assign grant_data = alu_ready ? alu_data : mem_data;

    // Set is applied after clear so a same-edge claim keeps the bit.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (fire) begin
            clr_mask[grant_rd] = 1'b1;
        end
        if (issue_valid) begin
            set_mask[issue_rd] = 1'b1;
        end
        busy_next    = (busy & ~clr_mask) | set_mask;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PRIO_ALU;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            write_data <= '0;
            busy       <= '0;
        end else begin
            if (alu_ready) begin
                state <= PRIO_MEM;
            end else if (mem_ready) begin
                state <= PRIO_ALU;
            end
            wb_en <= fire && (grant_rd != '0);
            if (fire) begin
                wb_rd      <= grant_rd;
                write_data <= grant_data;
            end
            busy <= busy_next;
        end
    end

    rd_decoder #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rd_decoder (
        .en    (wb_en),
        .rd    (wb_rd),
        .onehot(write_enable)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table, corner sequences and randomized checks of regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [31:0] write_enable;
    logic [31:0] write_data;
    logic [31:0] busy;

    int n_vec;
    int n_err;

    regfile_wb_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .write_enable(write_enable),
        .write_data  (write_data),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ird;
        logic        ar;
        logic        mr;
        logic [31:0] we;
        logic [31:0] wd;
        logic [31:0] bz;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic iv, input logic [4:0] ird,
        input logic ar, input logic mr,
        input logic [31:0] we, input logic [31:0] wd, input logic [31:0] bz);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.iv = iv; v.ird = ird;
        v.ar = ar; v.mr = mr;
        v.we = we; v.wd = wd; v.bz = bz;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model state: which side a tie favours, and the expected outputs.
    bit          m_prio_mem;
    logic [31:0] m_pend;
    logic [31:0] m_we;
    logic [31:0] m_wd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;

        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0, 1, 0, 32'h20,  32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(0, 0, 0,            1, 0, 32'h1234,    0, 0, 0, 1, 32'h0,   32'h1234,     32'h0);
        tbl[2]  = mk(1, 3, 32'hA3,       1, 7, 32'hB7,      0, 0, 1, 0, 32'h08,  32'hA3,       32'h0);
        tbl[3]  = mk(1, 3, 32'hA3,       1, 7, 32'hB7,      0, 0, 0, 1, 32'h80,  32'hB7,       32'h0);
        tbl[4]  = mk(1, 3, 32'hA3,       1, 7, 32'hB7,      0, 0, 1, 0, 32'h08,  32'hA3,       32'h0);
        tbl[5]  = mk(1, 3, 32'hA3,       1, 7, 32'hB7,      0, 0, 0, 1, 32'h80,  32'hB7,       32'h0);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0,           1, 9, 0, 0, 32'h0,   32'hB7,       32'h200);
        tbl[7]  = mk(1, 9, 32'h99,       0, 0, 0,           1, 9, 1, 0, 32'h200, 32'h99,       32'h200);
        tbl[8]  = mk(1, 9, 32'h55,       0, 0, 0,           0, 0, 1, 0, 32'h200, 32'h55,       32'h0);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 0, 32'h0,   32'h55,       32'h0);
        tbl[10] = mk(0, 0, 0,            1, 4, 32'h44,      1, 4, 0, 1, 32'h10,  32'h44,       32'h10);
        tbl[11] = mk(1, 4, 32'h77,       0, 0, 0,           1, 0, 1, 0, 32'h10,  32'h77,       32'h0);
        tbl[12] = mk(1, 2, 32'h22,       0, 0, 0,           0, 0, 1, 0, 32'h04,  32'h22,       32'h0);
        tbl[13] = mk(1, 2, 32'h22,       1, 6, 32'h66,      0, 0, 0, 1, 32'h40,  32'h66,       32'h0);

        idle_inputs();
        reset = 1'b1;
        alu_valid = 1'b1;
        mem_valid = 1'b1;
        #1;
        chk("rst_alu_ready", {31'b0, alu_ready}, 32'h0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_write_enable", write_enable, 32'h0);
        chk("rst_write_data", write_data, 32'h0);
        chk("rst_busy", busy, 32'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
            #1;
            chk($sformatf("tbl%0d_alu_ready", i), {31'b0, alu_ready}, {31'b0, tbl[i].ar});
            chk($sformatf("tbl%0d_mem_ready", i), {31'b0, mem_ready}, {31'b0, tbl[i].mr});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_write_enable", i), write_enable, tbl[i].we);
            chk($sformatf("tbl%0d_write_data", i), write_data, tbl[i].wd);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bz);
        end

        // Claim and write r12 together, then reset asynchronously mid-cycle.
        @(negedge clk);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd12;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hC0C0;
        #1;
        chk("r12_mem_ready", {31'b0, mem_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("r12_write_enable", write_enable, 32'h1000);
        chk("r12_busy", busy, 32'h1000);
        #1;
        idle_inputs();
        alu_valid = 1'b1; mem_valid = 1'b1;
        reset = 1'b1;
        #1;
        chk("async_write_enable", write_enable, 32'h0);
        chk("async_write_data", write_data, 32'h0);
        chk("async_busy", busy, 32'h0);
        chk("async_alu_ready", {31'b0, alu_ready}, 32'h0);
        chk("async_mem_ready", {31'b0, mem_ready}, 32'h0);
        #1;
        reset = 1'b0;
        alu_rd = 5'd1; alu_data = 32'h11;
        mem_rd = 5'd2; mem_data = 32'h22;
        #1;
        chk("post_rst_alu_ready", {31'b0, alu_ready}, 32'h1);
        chk("post_rst_mem_ready", {31'b0, mem_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("post_rst_write_enable", write_enable, 32'h2);
        chk("post_rst_busy", busy, 32'h0);

        // Tie state now favours MEM; an ALU request is killed by reset.
        @(negedge clk);
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
        #1;
        reset = 1'b1;
        #1;
        chk("kill_alu_ready", {31'b0, alu_ready}, 32'h0);
        @(posedge clk);
        #2;
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("kill_write_enable", write_enable, 32'h0);
        chk("kill_write_data", write_data, 32'h0);
        chk("kill_busy", busy, 32'h0);
        @(negedge clk);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
        #1;
        chk("fsm_rst_alu_ready", {31'b0, alu_ready}, 32'h1);
        chk("fsm_rst_mem_ready", {31'b0, mem_ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("fsm_rst_write_enable", write_enable, 32'h08);

        // Randomized traffic against the reference model.
        do_reset();
        m_prio_mem = 1'b0;
        m_pend = '0;
        m_we = '0;
        m_wd = '0;
        for (int c = 0; c < 400; c++) begin
            logic        e_a;
            logic        e_m;
            logic [4:0]  g_rd;
            logic [31:0] g_d;
            @(negedge clk);
            alu_valid   = 1'($urandom_range(0, 1));
            alu_rd      = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            mem_valid   = 1'($urandom_range(0, 1));
            mem_rd      = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            mem_data    = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            #1;
            e_a = alu_valid && (!mem_valid || !m_prio_mem);
            e_m = mem_valid && (!alu_valid || m_prio_mem);
            chk("rnd_alu_ready", {31'b0, alu_ready}, {31'b0, e_a});
            chk("rnd_mem_ready", {31'b0, mem_ready}, {31'b0, e_m});
            @(posedge clk);
            if (e_a || e_m) begin
                g_rd = e_a ? alu_rd : mem_rd;
                g_d  = e_a ? alu_data : mem_data;
                m_prio_mem = e_a;
                m_we = (g_rd != 0) ? (32'd1 << g_rd) : 32'd0;
                m_wd = g_d;
                m_pend[g_rd] = 1'b0;
            end else begin
                m_we = '0;
            end
            if (issue_valid && issue_rd != 0) begin
                m_pend[issue_rd] = 1'b1;
            end
            m_pend[0] = 1'b0;
            #1;
            chk("rnd_write_enable", write_enable, m_we);
            chk("rnd_write_data", write_data, m_wd);
            chk("rnd_busy", busy, m_pend);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
